// File: rtl/elastic_operator.sv
// rtl/elastic_operator.sv - dataflow operator node: multi-input join, output FIFO, per-consumer fanout acks
// A consumer is acked at most once per FIFO head; the head pops once every consumer has been served.
module elastic_operator #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 2,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 2,
  parameter string                 OP          = "add",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic [31:0]                      fire_count,
  output logic                             proto_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam int OPC = (OP == "addi") ? 1 : (OP == "subi") ? 2 : (OP == "muli") ? 3 :
                       (OP == "add")  ? 4 : (OP == "sub")  ? 5 : (OP == "mul")  ? 6 :
                       (OP == "and")  ? 7 : (OP == "or")   ? 8 : (OP == "xor")  ? 9 : 0;

  logic [INPUT_SIZE-1:0]  has_q, has_d, req_l_q, cap, viol;
  logic [DATA_WIDTH-1:0]  hold_q [INPUT_SIZE];
  // Sized to the pointer range so DEPTH=1 never indexes past the array.
  logic [DATA_WIDTH-1:0]  mem_q [2**PW];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic [OUTPUT_SIZE-1:0] served_q, served_all, issue, ack_r_q;
  logic [DATA_WIDTH-1:0]  dout_q, result;
  logic [31:0]            fire_count_q;
  logic                   proto_err_q;
  logic                   nonempty, pop, fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    nonempty   = (level_q != '0);
    issue      = nonempty ? (req_r & ~served_q) : '0;
    served_all = served_q | issue;
    pop        = nonempty && (&served_all);
    fire       = (&has_q) && ((level_q != LVL_FULL) || pop);
    cap        = ack_l & ~has_q;
    viol       = ack_l & has_q;
    has_d      = fire ? '0 : (has_q | cap);
    level_d    = level_q;
    if (fire && !pop)      level_d = level_q + LW'(1);
    else if (!fire && pop) level_d = level_q - LW'(1);
  end

  always_comb begin
    result = hold_q[0];
    case (OPC)
      1: result = hold_q[0] + IMMEDIATE;
      2: result = hold_q[0] - IMMEDIATE;
      3: result = hold_q[0] * IMMEDIATE;
      default: begin
        for (int i = 1; i < INPUT_SIZE; i++) begin
          case (OPC)
            4:       result = result + hold_q[i];
            5:       result = result - hold_q[i];
            6:       result = result * hold_q[i];
            7:       result = result & hold_q[i];
            8:       result = result | hold_q[i];
            9:       result = result ^ hold_q[i];
            default: result = result;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_q        <= '0;
      req_l_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      served_q     <= '0;
      ack_r_q      <= '0;
      dout_q       <= '0;
      fire_count_q <= '0;
      proto_err_q  <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) hold_q[i] <= '0;
      for (int k = 0; k < 2**PW; k++) mem_q[k] <= '0;
    end else begin
      has_q   <= has_d;
      req_l_q <= ~has_d;
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (cap[i]) hold_q[i] <= din[DATA_WIDTH*i +: DATA_WIDTH];
      end
      if (|viol) proto_err_q <= 1'b1;
      if (fire) begin
        mem_q[wr_ptr_q] <= result;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        fire_count_q    <= fire_count_q + 32'd1;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      served_q <= pop ? '0 : served_all;
      ack_r_q  <= issue;
      if (|issue) dout_q <= mem_q[rd_ptr_q];
      level_q  <= level_d;
    end
  end

  assign req_l      = req_l_q;
  assign ack_r      = ack_r_q;
  assign dout       = dout_q;
  assign level      = level_q;
  assign fire_count = fire_count_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_elastic_operator.sv
// tb/tb_elastic_operator.sv - randomized and directed checks of elastic_operator against a token-queue model
module tb_elastic_operator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [2:0]  req_l, ack_l, req_r, ack_r;
  logic [23:0] din;
  logic [7:0]  dout;
  logic [1:0]  level;
  logic [31:0] fire_count;
  logic        proto_err;

  logic        m_req_l, m_ack_l, m_req_r, m_ack_r, m_perr;
  logic [7:0]  m_din, m_dout;
  logic [0:0]  m_level;
  logic [31:0] m_fc;

  logic [1:0]  a_req_l, a_ack_l, a_level;
  logic [63:0] a_din;
  logic        a_req_r, a_ack_r, a_perr;
  logic [31:0] a_dout, a_fc;

  elastic_operator #(.DATA_WIDTH(8), .INPUT_SIZE(3), .OUTPUT_SIZE(3), .DEPTH(2), .OP("sub")) dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din), .req_r(req_r), .ack_r(ack_r),
    .dout(dout), .level(level), .fire_count(fire_count), .proto_err(proto_err));

  elastic_operator #(.DATA_WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(1), .OP("muli"), .IMMEDIATE(8'd2)) dut_muli (
    .clk(clk), .rst(rst), .req_l(m_req_l), .ack_l(m_ack_l), .din(m_din), .req_r(m_req_r), .ack_r(m_ack_r),
    .dout(m_dout), .level(m_level), .fire_count(m_fc), .proto_err(m_perr));

  elastic_operator dut_add (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r), .ack_r(a_ack_r),
    .dout(a_dout), .level(a_level), .fire_count(a_fc), .proto_err(a_perr));

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: k-th tokens of every input join into the k-th result, which every consumer must see in order.
  logic [7:0] in_q [3][$];
  logic [7:0] exp_q [3][$];
  int n_fold = 0;

  function automatic void try_fold();
    logic [7:0] a, b, c, r;
    while (in_q[0].size() > 0 && in_q[1].size() > 0 && in_q[2].size() > 0) begin
      a = in_q[0].pop_front();
      b = in_q[1].pop_front();
      c = in_q[2].pop_front();
      r = 8'((int'(a) - int'(b) - int'(c)) % 256);
      for (int j = 0; j < 3; j++) exp_q[j].push_back(r);
      n_fold++;
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 3; i++) begin
      in_q[i].delete();
      exp_q[i].delete();
    end
    n_fold = 0;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check_val("level_bound", level <= 2'd2, 1'b1);
      for (int j = 0; j < 3; j++) begin
        if (ack_r[j]) begin
          if (exp_q[j].size() == 0) check_val($sformatf("extra_ack_c%0d", j), 1, 0);
          else check_val($sformatf("dout_c%0d", j), dout, exp_q[j].pop_front());
        end
      end
    end
  end

  task automatic send_one(input int i, input logic [7:0] v);
    int t = 0;
    while (!req_l[i] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_l[i]) check_val("send_one_timeout", 0, 1);
    else begin
      ack_l[i] = 1'b1;
      din[8*i +: 8] = v;
      in_q[i].push_back(v);
      try_fold();
      @(negedge clk);
      ack_l[i] = 1'b0;
    end
  endtask

  task automatic send_tok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    int t = 0;
    while (req_l != 3'b111 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (req_l != 3'b111) check_val("send_tok_timeout", 0, 1);
    else begin
      ack_l = 3'b111;
      din = {c, b, a};
      in_q[0].push_back(a);
      in_q[1].push_back(b);
      in_q[2].push_back(c);
      try_fold();
      @(negedge clk);
      ack_l = 3'b000;
    end
  endtask

  task automatic check_drained(input string tag);
    for (int j = 0; j < 3; j++) check_val($sformatf("%s_pending_c%0d", tag, j), exp_q[j].size(), 0);
    check_val({tag, "_level"}, level, 0);
  endtask

  initial begin
    int stall_cnt [3];
    int t, mx;
    logic [7:0]  v;
    logic [31:0] x, y;
    rst = 1'b0;
    ack_l = '0; din = '0; req_r = '0;
    m_ack_l = 1'b0; m_din = '0; m_req_r = 1'b1;
    a_ack_l = '0; a_din = '0; a_req_r = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_req_l", req_l, 0);
    check_val("rst_ack_r", ack_r, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_level", level, 0);
    check_val("rst_fire_count", fire_count, 0);
    check_val("rst_proto_err", proto_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("first_req_l", req_l, 3'b111);

    // Latency: capture edge, fire edge, then ack.
    req_r = 3'b111;
    send_tok(8'd5, 8'd7, 8'd1);
    check_val("lat_e0_ack", ack_r, 0);
    @(negedge clk);
    check_val("lat_e1_ack", ack_r, 0);
    check_val("lat_e1_level", level, 1);
    @(negedge clk);
    check_val("lat_e2_ack", ack_r, 3'b111);
    check_val("lat_e2_dout", dout, 8'hFD);
    check_val("lat_fire_count", fire_count, 1);
    @(negedge clk);
    check_val("lat_level", level, 0);

    // Staggered consumers: head pops only once the last consumer is served.
    req_r = 3'b000;
    send_tok(8'd10, 8'd0, 8'd0);
    send_tok(8'd11, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    req_r = 3'b001;
    repeat (5) @(negedge clk);
    req_r = 3'b011;
    repeat (4) @(negedge clk);
    check_val("stagger_level_held", level, 2);
    req_r = 3'b111;
    repeat (4) @(negedge clk);
    check_drained("stagger");

    // Full FIFO with no consumer: third token held, no fourth capture.
    req_r = 3'b000;
    for (int i = 0; i < 3; i++) stall_cnt[i] = 0;
    repeat (20) begin
      @(negedge clk);
      ack_l = '0;
      for (int i = 0; i < 3; i++) begin
        if (req_l[i]) begin
          v = 8'($urandom);
          ack_l[i] = 1'b1;
          din[8*i +: 8] = v;
          in_q[i].push_back(v);
          stall_cnt[i]++;
        end
      end
      try_fold();
    end
    @(negedge clk);
    ack_l = '0;
    @(negedge clk);
    check_val("stall_level", level, 2);
    check_val("stall_req_l", req_l, 0);
    for (int i = 0; i < 3; i++) check_val($sformatf("stall_caps_in%0d", i), stall_cnt[i], 3);
    check_val("stall_fire_count", fire_count, n_fold - 1);
    req_r = 3'b111;
    repeat (12) @(negedge clk);
    check_drained("stall");
    check_val("stall_fire_count_end", fire_count, n_fold);

    // Protocol violation: extra ack_l while holding is dropped.
    send_one(0, 8'd5);
    check_val("proto_holding", req_l[0], 0);
    ack_l[0] = 1'b1;
    din[7:0] = 8'd99;
    @(negedge clk);
    ack_l[0] = 1'b0;
    check_val("proto_err_set", proto_err, 1);
    send_one(1, 8'd0);
    send_one(2, 8'd0);
    repeat (4) @(negedge clk);
    check_drained("proto");

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      ack_l = '0;
      for (int i = 0; i < 3; i++) begin
        if (req_l[i] && $urandom_range(0, 2) == 0) begin
          v = 8'($urandom);
          ack_l[i] = 1'b1;
          din[8*i +: 8] = v;
          in_q[i].push_back(v);
        end
      end
      try_fold();
      req_r = 3'($urandom);
    end
    @(negedge clk);
    ack_l = '0;
    req_r = 3'b111;
    mx = 0;
    for (int i = 0; i < 3; i++) if (in_q[i].size() > mx) mx = in_q[i].size();
    for (int i = 0; i < 3; i++) if (in_q[i].size() < mx) send_one(i, 8'($urandom));
    repeat (20) @(negedge clk);
    check_drained("rand");
    check_val("rand_fire_count", fire_count, n_fold);
    check_val("proto_err_sticky", proto_err, 1);

    // Single-input muli (DEPTH=1) and default 32-bit add nodes.
    for (int k = 0; k < 5; k++) begin
      v = (k == 0) ? 8'h90 : 8'($urandom);
      t = 0;
      while (!m_req_l && t < 20) begin @(negedge clk); t++; end
      m_ack_l = 1'b1; m_din = v;
      @(negedge clk);
      m_ack_l = 1'b0;
      t = 0;
      while (!m_ack_r && t < 10) begin @(negedge clk); t++; end
      check_val("muli_ack", m_ack_r, 1);
      check_val("muli_dout", m_dout, 8'(v * 8'd2));
      x = (k == 0) ? 32'd3 : $urandom;
      y = (k == 0) ? 32'd4 : $urandom;
      t = 0;
      while (a_req_l != 2'b11 && t < 20) begin @(negedge clk); t++; end
      a_ack_l = 2'b11; a_din = {y, x};
      @(negedge clk);
      a_ack_l = 2'b00;
      t = 0;
      while (!a_ack_r && t < 10) begin @(negedge clk); t++; end
      check_val("add_ack", a_ack_r, 1);
      check_val("add_dout", a_dout, x + y);
    end
    check_val("muli_fire_count", m_fc, 5);
    check_val("add_fire_count", a_fc, 5);

    // Asynchronous reset mid-transfer.
    req_r = 3'b000;
    send_tok(8'd1, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    send_one(0, 8'd9);
    check_val("arst_pre_level", level, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("arst_req_l", req_l, 0);
    check_val("arst_ack_r", ack_r, 0);
    check_val("arst_dout", dout, 0);
    check_val("arst_level", level, 0);
    check_val("arst_fire_count", fire_count, 0);
    check_val("arst_proto_err", proto_err, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b1;
    req_r = 3'b111;
    @(negedge clk);
    check_val("arst_req_l_release", req_l, 3'b111);
    send_tok(8'd20, 8'd3, 8'd2);
    repeat (5) @(negedge clk);
    check_drained("arst");
    check_val("arst_fire_count_new", fire_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/elastic_operator.md
# elastic_operator

Parametrised dataflow operator node with multi-input join, independent per-consumer fanout acknowledgement and an output FIFO of configurable depth. It extends the single-register operator node so that a slow consumer does not stall the others. It also lets the producer side keep firing while earlier results wait. It sits between producer/consumer ports and other operator nodes inside generated dataflow graphs.

## Interface
- DATA_WIDTH, 32, token width in bits
- INPUT_SIZE, 2, number of input channels (1..4)
- OUTPUT_SIZE, 1, number of fanout consumers (1..8)
- DEPTH, 2, output FIFO entries (power of two, 1..16)
- OP, "add", one of reg/in/out/addi/subi/muli/add/sub/mul/and/or/xor
- IMMEDIATE, 0, constant for addi/subi/muli
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_l  out  INPUT_SIZE  per-input token request to upstream
- ack_l  in  INPUT_SIZE  per-input one-cycle token-valid pulse from upstream
- din  in  DATA_WIDTH*INPUT_SIZE  input data; slice i = bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
- req_r  in  OUTPUT_SIZE  per-consumer request
- ack_r  out  OUTPUT_SIZE  per-consumer one-cycle delivery pulse
- dout  out  DATA_WIDTH  delivered token, valid while any ack_r bit is high
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- fire_count  out  32  number of fires, wraps modulo 2^32
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Per input i: 1-deep holding register and has[i] flag. At an edge with ack_l[i]=1 and has[i]=0, capture the din slice and set has[i].
- req_l[i] is registered and equals ~has_next[i].
- ack_l[i]=1 while has[i]=1 is a violation. The data is dropped, the held token is unchanged, and proto_err is set until reset.
- Fire at an edge when all has[i]=1 and (level<DEPTH or a pop occurs at the same edge). A fire pushes the result, clears all has[i] and increments fire_count.
- Result for reg/in/out is in0.
- Result for addi/subi/muli is in0 op IMMEDIATE.
- Result for add/sub/mul/and/or/xor is a left fold: in0 op in1 op in2 ... For example, sub = in0-in1-in2.
- All arithmetic is unsigned, modulo 2^DATA_WIDTH; mul keeps the low DATA_WIDTH bits.
- Output side: served[OUTPUT_SIZE] mask tracks delivery of the FIFO head.
- At an edge where the FIFO is non-empty, req_r[j]=1 and served[j]=0: set ack_r[j]=1 for the next cycle and set served[j].
- Every ack issued at an edge also loads the dout register with the head value.
- Consumers may be served at different edges. Each consumer receives exactly one ack per token, in FIFO order.
- When served_next is all ones, pop the head at that same edge and clear served.
- ack_r bits not issued at an edge return to 0.
- Asserting rst (at any time) immediately clears all holding registers, has, the FIFO, served, level, ack_r, req_l, dout, fire_count and proto_err. In-flight tokens are discarded.

## Timing
- Reset values: req_l=0, ack_r=0, dout=0, level=0, fire_count=0, proto_err=0.
- First edge after rst deasserts: req_l goes to all ones.
- Capture to fire: 1 edge once all inputs are held. Fire to first possible ack_r: 1 edge. Pipeline input-to-output latency is 2 cycles after the last input arrives.
- Output throughput: one token per cycle per consumer when the consumer holds req_r high.
- Full FIFO with no pop: fire stalls, has stays set and req_l stays low. No token is lost.
- Full FIFO with a pop at the same edge: fire proceeds and level is unchanged.
- Fire and pop at the same edge: level is unchanged. Fire only: level+1. Pop only: level-1.
- FIFO pointers wrap modulo DEPTH.

## Test plan
- INPUT_SIZE=2, OP=add: inputs 3 and 4, consumer req high -> one ack_r pulse with dout=7 two cycles after the later capture; fire_count=1.
- OUTPUT_SIZE=3: tokens 10, 11; consumers request at cycles 0, 5 and 9 -> each consumer gets an ack with 10 then 11. The head pops only at the edge of the last consumer's ack for that token; level returns to 0.
- DEPTH=2, no req_r, continuous upstream -> level reaches 2, a third token is held with req_l low, and no fourth capture occurs. Enabling req_r drains the tokens in order with no loss or duplication.
- DATA_WIDTH=8, OP=muli, IMMEDIATE=2, input 0x90 -> dout=0x20. OP=sub with 3 inputs 5, 7, 1 -> dout=0xFD.
- ack_l[0] pulsed while has[0]=1 -> proto_err=1 and stays high; the held token is delivered unchanged.
- rst driven low mid-transfer (level=1, has partially set, asynchronously between edges) -> all outputs go to their reset values immediately. After release, the first token delivered is a new one.
